// File: rtl/clk_user_div_gen.sv
// Runtime-programmable per-channel clock-enable / divided-clock generator with sync strobe and lock status.
// Latency: outputs registered, new ratio takes effect on the channel's wrap edge (next edge if disabled).
// Backpressure: cfg_ready drops per channel while a ratio is pending; optional duty control via CLK_USER_DIV_GEN_DUTY_EN.
module clk_user_div_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in1,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLK_USER_DIV_GEN_DUTY_EN
    input  logic [DIV_W-1:0]  cfg_high,
`endif
    input  logic              sync_strobe,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] CNT_RST  = DIV_W'(DEFAULT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam int               LCK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_CYCLES);
    localparam logic [LCK_W-1:0] LCK_ONE  = LCK_W'(1);

    logic [CH_W:0]       ch_ext;
    logic [NUM_CH-1:0]   pend_vld;
    logic [NUM_CH-1:0]   apply;
    logic [LCK_W-1:0]    lock_cnt;
    logic [LCK_W-1:0]    lock_nxt;

    // Widened so out-of-range channel codes never match a real channel.
    assign ch_ext = {1'b0, cfg_ch};

    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_ext == (CH_W + 1)'(i)) cfg_ready = ~pend_vld[i];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_act;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] pend_div;
        logic [DIV_W-1:0] div_nxt;
        logic [DIV_W-1:0] cnt_nxt;
        logic [DIV_W-1:0] high_nxt;
        logic             pend_q;
        logic             en_q;
        logic             out_q;
        logic             wrap;
        logic             cfg_wr;
`ifdef CLK_USER_DIV_GEN_DUTY_EN
        logic [DIV_W-1:0] high_act;
        logic [DIV_W-1:0] pend_high;
`endif

        assign cfg_wr   = cfg_valid && ~pend_q && (ch_ext == (CH_W + 1)'(i));
        assign wrap     = (div_act != '0) && (cnt == div_act - DIV_ONE);
        // Applying only on wrap/sync/disabled keeps every period whole.
        assign apply[i] = pend_q && ((div_act == '0) || wrap || sync_strobe);
        assign div_nxt  = apply[i] ? pend_div : div_act;
`ifdef CLK_USER_DIV_GEN_DUTY_EN
        assign high_nxt = apply[i] ? pend_high : high_act;
`else
        assign high_nxt = div_nxt >> 1;
`endif
        assign cnt_nxt  = ((div_nxt == '0) || apply[i] || wrap || sync_strobe) ? '0 : cnt + DIV_ONE;

        always_ff @(posedge clk_in1 or negedge reset_n) begin
            if (!reset_n) begin
                div_act   <= DIV_RST;
                cnt       <= CNT_RST;
                pend_q    <= 1'b0;
                pend_div  <= '0;
                en_q      <= 1'b0;
                out_q     <= 1'b0;
`ifdef CLK_USER_DIV_GEN_DUTY_EN
                high_act  <= DIV_W'(DEFAULT_DIV / 2);
                pend_high <= '0;
`endif
            end else begin
                div_act <= div_nxt;
                cnt     <= cnt_nxt;
                en_q    <= (div_nxt != '0) && (cnt_nxt == '0);
                out_q   <= (div_nxt != '0) && (cnt_nxt < high_nxt);
`ifdef CLK_USER_DIV_GEN_DUTY_EN
                high_act <= high_nxt;
`endif
                if (cfg_wr) begin
                    pend_q   <= 1'b1;
                    pend_div <= cfg_div;
`ifdef CLK_USER_DIV_GEN_DUTY_EN
                    pend_high <= cfg_high;
`endif
                end else if (apply[i]) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign pend_vld[i] = pend_q;
        assign clk_en[i]   = en_q;
        assign clk_out[i]  = out_q;
    end

    assign lock_nxt = ((|apply) || sync_strobe) ? '0 :
                      (lock_cnt == LOCK_MAX)    ? lock_cnt : lock_cnt + LCK_ONE;

    always_ff @(posedge clk_in1 or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            lock_cnt <= lock_nxt;
            locked   <= (lock_nxt == LOCK_MAX);
        end
    end

endmodule
